// File: rtl/matrix_load_ctrl.sv
// Purpose: sequences config + compact row-major byte stream into 5x5 grid operand registers, then runs the datapath.
// Latency: op_start one cycle after the last byte; done one cycle after op_done is seen in WAIT.
// Backpressure: in_ready/cfg_ready decode from state only; in_valid gaps stall loading with no side effects.
module matrix_load_ctrl #(
    parameter int DATA_W = 8,
    parameter int DIM    = 5,
    parameter int MAT_W  = DIM * DIM * DATA_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    input  logic [2:0]       cfg_size,
    input  logic             cfg_two,
    output logic             cfg_ready,
    input  logic             in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic             in_ready,
    output logic [MAT_W-1:0] matrix1_out,
    output logic [MAT_W-1:0] matrix2_out,
    output logic [2:0]       size_out,
    output logic             op_start,
    input  logic             op_done,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int PW = $clog2(MAT_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state;
    logic       two_q;
    logic [2:0] row;
    logic [2:0] col;

    logic          size_legal;
    logic [2:0]    last_idx;
    logic          last_col;
    logic          last_cell;
    logic [PW-1:0] cell_idx;
    logic [PW-1:0] wr_hi;

    // Handshake and status flags are pure decodes of the state register.
    assign cfg_ready = (state == S_IDLE);
    assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign busy      = (state != S_IDLE);

    // Config legality, end-of-row/end-of-matrix detection and grid write position.
    always_comb begin
        size_legal = (cfg_size >= 3'd2) && (cfg_size <= 3'(DIM));
        last_idx   = size_out - 3'd1;
        last_col   = (col == last_idx);
        last_cell  = last_col && (row == last_idx);
        cell_idx   = PW'(DIM) * PW'(row) + PW'(col);
        wr_hi      = PW'(MAT_W - 1) - PW'(DATA_W) * cell_idx;
    end

    // Main sequencer: config latch, scatter loading, datapath handshake, one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            two_q       <= 1'b0;
            row         <= 3'd0;
            col         <= 3'd0;
            matrix1_out <= '0;
            matrix2_out <= '0;
            size_out    <= 3'd0;
            op_start    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            op_start <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        if (size_legal) begin
                            size_out    <= cfg_size;
                            two_q       <= cfg_two;
                            matrix1_out <= '0;
                            matrix2_out <= '0;
                            row         <= 3'd0;
                            col         <= 3'd0;
                            state       <= S_LOAD_A;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (in_valid) begin
                        if (state == S_LOAD_A) begin
                            matrix1_out[wr_hi -: DATA_W] <= in_data;
                        end else begin
                            matrix2_out[wr_hi -: DATA_W] <= in_data;
                        end
                        if (last_cell) begin
                            row <= 3'd0;
                            col <= 3'd0;
                            if ((state == S_LOAD_A) && two_q) begin
                                state <= S_LOAD_B;
                            end else begin
                                state    <= S_START;
                                op_start <= 1'b1;
                            end
                        end else if (last_col) begin
                            col <= 3'd0;
                            row <= row + 3'd1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (op_done) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Purpose: directed checks of matrix_load_ctrl config, loading, handshake and reset behaviour.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: in_valid gaps and ignored op_done/cfg_valid exercised explicitly.
module tb_matrix_load_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cfg_valid;
    logic [2:0]   cfg_size;
    logic         cfg_two;
    logic         cfg_ready;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [199:0] matrix1_out;
    logic [199:0] matrix2_out;
    logic [2:0]   size_out;
    logic         op_start;
    logic         op_done;
    logic         busy;
    logic         done;
    logic         err;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [199:0] M_N2_A = {16'h0102, 24'h0, 16'h0304, 144'h0};
    localparam logic [199:0] M_N2_B = {16'h0506, 24'h0, 16'h0708, 144'h0};
    localparam logic [199:0] M_N5   = 200'h0102030405060708090A0B0C0D0E0F10111213141516171819;
    localparam logic [199:0] M_N3   = {24'h010203, 16'h0, 24'h040506, 16'h0, 24'h070809, 96'h0};

    matrix_load_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_size    (cfg_size),
        .cfg_two     (cfg_two),
        .cfg_ready   (cfg_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .matrix1_out (matrix1_out),
        .matrix2_out (matrix2_out),
        .size_out    (size_out),
        .op_start    (op_start),
        .op_done     (op_done),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkm(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input logic [2:0] n, input logic two);
        cfg_valid = 1'b1;
        cfg_size  = n;
        cfg_two   = two;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    // Wait state -> op_done -> done pulse -> back to IDLE.
    task automatic finish_op(input string tag);
        step();
        chk1({tag, " wait busy"}, busy, 1'b1);
        chk1({tag, " wait no done"}, done, 1'b0);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk1({tag, " done pulse"}, done, 1'b1);
        step();
        chk1({tag, " done low"}, done, 1'b0);
        chk1({tag, " cfg_ready"}, cfg_ready, 1'b1);
        chk1({tag, " idle busy"}, busy, 1'b0);
    endtask

    task automatic run_s1(input string tag);
        send_cfg(3'd2, 1'b1);
        chk1({tag, " load in_ready"}, in_ready, 1'b1);
        chk1({tag, " load cfg_ready"}, cfg_ready, 1'b0);
        chk3({tag, " size_out"}, size_out, 3'd2);
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            if (i == 7) chk1({tag, " no early start"}, op_start, 1'b0);
        end
        in_valid = 1'b0;
        chk1({tag, " op_start"}, op_start, 1'b1);
        chk1({tag, " in_ready after"}, in_ready, 1'b0);
        chkm({tag, " m1"}, matrix1_out, M_N2_A);
        chkm({tag, " m2"}, matrix2_out, M_N2_B);
        finish_op(tag);
        chk1({tag, " op_start low"}, op_start, 1'b0);
        chkm({tag, " m1 held"}, matrix1_out, M_N2_A);
    endtask

    initial begin
        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        cfg_size  = 3'd0;
        cfg_two   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        op_done   = 1'b0;
        step();
        step();
        chk1("rst cfg_ready", cfg_ready, 1'b1);
        chk1("rst busy", busy, 1'b0);
        chk1("rst in_ready", in_ready, 1'b0);
        chkm("rst m1", matrix1_out, 200'h0);
        chk3("rst size", size_out, 3'd0);
        reset_n = 1'b1;
        step();

        // n=2, two operands, back-to-back bytes.
        run_s1("s1");

        // n=5, single operand; B cleared by the new config.
        send_cfg(3'd5, 1'b0);
        chkm("s2 m1 cleared", matrix1_out, 200'h0);
        for (int i = 1; i <= 25; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            if (i == 24) begin
                chk1("s2 in_ready at 24", in_ready, 1'b1);
                chk1("s2 no start at 24", op_start, 1'b0);
            end
        end
        in_valid = 1'b0;
        chk1("s2 op_start", op_start, 1'b1);
        chk1("s2 in_ready after", in_ready, 1'b0);
        chkm("s2 m1", matrix1_out, M_N5);
        chkm("s2 m2", matrix2_out, 200'h0);
        finish_op("s2");

        // n=3 with gaps; garbage on in_data while invalid; cfg_valid mid-load ignored.
        send_cfg(3'd3, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'(i);
            cfg_valid = (i == 4);
            cfg_size  = 3'd2;
            step();
            cfg_valid = 1'b0;
            if (i == 9) chk1("s3 op_start", op_start, 1'b1);
            in_valid = 1'b0;
            in_data  = 8'hFF;
            step();
        end
        chkm("s3 m1", matrix1_out, M_N3);
        chk3("s3 size kept", size_out, 3'd3);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk1("s3 done", done, 1'b1);
        step();

        // Illegal sizes rejected.
        send_cfg(3'd6, 1'b1);
        chk1("s4 err6", err, 1'b1);
        chk1("s4 busy6", busy, 1'b0);
        chk1("s4 cfg_ready6", cfg_ready, 1'b1);
        step();
        chk1("s4 err low", err, 1'b0);
        send_cfg(3'd1, 1'b0);
        chk1("s4 err1", err, 1'b1);
        chk1("s4 busy1", busy, 1'b0);
        chkm("s4 m1 kept", matrix1_out, M_N3);
        chk3("s4 size kept", size_out, 3'd3);
        step();

        // op_done outside WAIT ignored.
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk1("s5 idle busy", busy, 1'b0);
        chk1("s5 idle done", done, 1'b0);
        send_cfg(3'd2, 1'b0);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk1("s5 load in_ready", in_ready, 1'b1);
        chk1("s5 load done", done, 1'b0);
        for (int i = 1; i <= 4; i++) send_byte(8'(8'h10 + i));
        chk1("s5 op_start", op_start, 1'b1);
        chkm("s5 m1", matrix1_out, {16'h1112, 24'h0, 16'h1314, 144'h0});
        finish_op("s5");

        // Async reset in the middle of an n=4 load.
        send_cfg(3'd4, 1'b1);
        for (int i = 1; i <= 3; i++) send_byte(8'(8'hA0 + i));
        #2;
        reset_n = 1'b0;
        #1;
        chk1("s6 cfg_ready", cfg_ready, 1'b1);
        chk1("s6 busy", busy, 1'b0);
        chk1("s6 in_ready", in_ready, 1'b0);
        chkm("s6 m1", matrix1_out, 200'h0);
        chk3("s6 size", size_out, 3'd0);
        step();
        reset_n = 1'b1;
        step();
        run_s1("s6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
